// File: rtl/y86_seq_controller.sv
// Multi-cycle phase sequencer for the sequential Y86-64 core: walks each instruction
// through fetch/decode/execute/memory/writeback/PC-update and runs both memory handshakes.
module y86_seq_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_ack,
    input  logic             imem_err,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_wr,
    output logic             decode_en,
    output logic             exec_en,
    output logic             cc_we,
    output logic             wb_en,
    output logic             pc_we,
    output logic             busy,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPD     = 4'd6,
        S_HALT      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    state_t           state_r;
    logic [3:0]       icode_r;
    logic [TW-1:0]    tmr_r;
    logic             imem_req_r;
    logic             dmem_req_r;
    logic             dmem_wr_r;
    logic             exec_en_r;
    logic             cc_we_r;
    logic             wb_en_r;
    logic             pc_we_r;
    logic             busy_r;
    logic [2:0]       stat_r;
    logic [CNT_W-1:0] retired_r;
    logic             icode_legal_s;

    // icode only becomes valid in the DECODE cycle, so the decode strobe is qualified
    // directly by the state register and the live opcode rather than registered ahead.
    assign icode_legal_s = (icode != 4'h0) && (icode <= 4'hB);
    assign decode_en     = (state_r == S_DECODE) && icode_legal_s;

    assign imem_req = imem_req_r;
    assign dmem_req = dmem_req_r;
    assign dmem_wr  = dmem_wr_r;
    assign exec_en  = exec_en_r;
    assign cc_we    = cc_we_r;
    assign wb_en    = wb_en_r;
    assign pc_we    = pc_we_r;
    assign busy     = busy_r;
    assign stat     = stat_r;
    assign retired  = retired_r;

    // Phase sequencer with registered strobes, requests, status and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            icode_r    <= 4'h0;
            tmr_r      <= '0;
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_wr_r  <= 1'b0;
            exec_en_r  <= 1'b0;
            cc_we_r    <= 1'b0;
            wb_en_r    <= 1'b0;
            pc_we_r    <= 1'b0;
            busy_r     <= 1'b0;
            stat_r     <= STAT_AOK;
            retired_r  <= '0;
        end else begin
            exec_en_r <= 1'b0;
            cc_we_r   <= 1'b0;
            wb_en_r   <= 1'b0;
            pc_we_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r    <= S_FETCH;
                        imem_req_r <= 1'b1;
                        tmr_r      <= '0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // An ack in the final wait cycle still counts as a good response.
                    if (imem_ack) begin
                        imem_req_r <= 1'b0;
                        if (imem_err) begin
                            state_r <= S_ERROR;
                            stat_r  <= STAT_ADR;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= S_DECODE;
                        end
                    end else if (tmr_r == TMR_LAST) begin
                        imem_req_r <= 1'b0;
                        state_r    <= S_ERROR;
                        stat_r     <= STAT_ADR;
                        busy_r     <= 1'b0;
                    end else begin
                        tmr_r <= tmr_r + TW'(1);
                    end
                end
                S_DECODE: begin
                    icode_r <= icode;
                    if (icode == 4'h0) begin
                        state_r <= S_HALT;
                        stat_r  <= STAT_HLT;
                        busy_r  <= 1'b0;
                    end else if (!icode_legal_s) begin
                        state_r <= S_ERROR;
                        stat_r  <= STAT_INS;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r   <= S_EXECUTE;
                        exec_en_r <= 1'b1;
                        cc_we_r   <= (icode == 4'h6);
                    end
                end
                S_EXECUTE: begin
                    case (icode_r)
                        4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: begin
                            state_r    <= S_MEMORY;
                            dmem_req_r <= 1'b1;
                            dmem_wr_r  <= (icode_r == 4'h4) || (icode_r == 4'h8) || (icode_r == 4'hA);
                            tmr_r      <= '0;
                        end
                        4'h2, 4'h3, 4'h6: begin
                            state_r <= S_WRITEBACK;
                            wb_en_r <= 1'b1;
                        end
                        4'h1, 4'h7: begin
                            state_r <= S_PCUPD;
                            pc_we_r <= 1'b1;
                        end
                        default: begin
                            state_r <= S_ERROR;
                            stat_r  <= STAT_INS;
                            busy_r  <= 1'b0;
                        end
                    endcase
                end
                S_MEMORY: begin
                    if (dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_wr_r  <= 1'b0;
                        if (dmem_err) begin
                            state_r <= S_ERROR;
                            stat_r  <= STAT_ADR;
                            busy_r  <= 1'b0;
                        end else if (icode_r == 4'h4) begin
                            state_r <= S_PCUPD;
                            pc_we_r <= 1'b1;
                        end else begin
                            state_r <= S_WRITEBACK;
                            wb_en_r <= 1'b1;
                        end
                    end else if (tmr_r == TMR_LAST) begin
                        dmem_req_r <= 1'b0;
                        dmem_wr_r  <= 1'b0;
                        state_r    <= S_ERROR;
                        stat_r     <= STAT_ADR;
                        busy_r     <= 1'b0;
                    end else begin
                        tmr_r <= tmr_r + TW'(1);
                    end
                end
                S_WRITEBACK: begin
                    state_r <= S_PCUPD;
                    pc_we_r <= 1'b1;
                end
                S_PCUPD: begin
                    retired_r  <= retired_r + CNT_W'(1);
                    state_r    <= S_FETCH;
                    imem_req_r <= 1'b1;
                    tmr_r      <= '0;
                end
                S_HALT, S_ERROR: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r    <= S_ERROR;
                    stat_r     <= STAT_INS;
                    busy_r     <= 1'b0;
                    imem_req_r <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_wr_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_seq_controller.sv
// Bench for y86_seq_controller: a per-instruction phase-list model predicts every
// output cycle by cycle under random opcodes, memory wait states and stray acks.
module tb_y86_seq_controller;

    localparam int T = 16;

    // Expected-vector bit positions
    localparam logic [8:0] IREQ = 9'b1_0000_0000;
    localparam logic [8:0] DREQ = 9'b0_1000_0000;
    localparam logic [8:0] DWR  = 9'b0_0100_0000;
    localparam logic [8:0] DEC  = 9'b0_0010_0000;
    localparam logic [8:0] EXE  = 9'b0_0001_0000;
    localparam logic [8:0] CC   = 9'b0_0000_1000;
    localparam logic [8:0] WB   = 9'b0_0000_0100;
    localparam logic [8:0] PC   = 9'b0_0000_0010;
    localparam logic [8:0] BUSY = 9'b0_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        imem_ack = 1'b0, imem_err = 1'b0, dmem_ack = 1'b0, dmem_err = 1'b0;
    logic        imem_req, dmem_req, dmem_wr, decode_en, exec_en, cc_we, wb_en, pc_we, busy;
    logic [2:0]  stat;
    logic [31:0] retired;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 32'd0;
    logic [2:0]  exp_stat = 3'd1;
    bit          stopped;

    y86_seq_controller #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .imem_ack(imem_ack), .imem_err(imem_err), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_wr(dmem_wr), .decode_en(decode_en),
        .exec_en(exec_en), .cc_we(cc_we), .wb_en(wb_en), .pc_we(pc_we), .busy(busy),
        .stat(stat), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive handshakes, compare all outputs, advance to just after the edge.
    task automatic tick(input string tag, input logic [8:0] ev, input logic ia, input logic ie,
                        input logic da, input logic de);
        imem_ack = ev[8] ? ia : 1'($urandom);
        imem_err = ev[8] ? ie : 1'($urandom);
        dmem_ack = ev[7] ? da : 1'($urandom);
        dmem_err = ev[7] ? de : 1'($urandom);
        #1;
        chk({tag, "_out"}, {23'd0, imem_req, dmem_req, dmem_wr, decode_en, exec_en,
                            cc_we, wb_en, pc_we, busy}, {23'd0, ev});
        chk({tag, "_stat"}, {29'd0, stat}, {29'd0, exp_stat});
        chk({tag, "_ret"}, retired, exp_ret);
        @(posedge clk);
        #1;
        imem_ack = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 32'd0;
        exp_stat = 3'd1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick("idle_start", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    // Sticky terminal state: nothing moves even with start toggling.
    task automatic stuck(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom);
            tick(tag, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        start = 1'b0;
    endtask

    // Reference model: phase list of one instruction. fw/dw = wait cycles before ack
    // (>= T means never acked).
    task automatic run_instr(input logic [3:0] k, input int fw, input bit ferr,
                             input int dw, input bit derr, output bit stop);
        bit got;
        bit is_mem;
        bit is_wr;
        stop = 1'b0;
        icode = k;
        got = 1'b0;
        for (int i = 0; i < T && !got; i++) begin
            tick("fetch", IREQ | BUSY, 1'(i == fw), ferr, 1'b0, 1'b0);
            got = (i == fw);
        end
        if (!got || ferr) begin
            exp_stat = 3'd3; stop = 1'b1; return;
        end
        if (k == 4'h0) begin
            tick("decode_halt", BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_stat = 3'd2; stop = 1'b1; return;
        end
        if (k > 4'hB) begin
            tick("decode_ins", BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_stat = 3'd4; stop = 1'b1; return;
        end
        tick("decode", DEC | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("execute", EXE | ((k == 4'h6) ? CC : 9'd0) | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        is_mem = (k == 4'h4) || (k == 4'h5) || (k >= 4'h8);
        is_wr  = (k == 4'h4) || (k == 4'h8) || (k == 4'hA);
        if (is_mem) begin
            got = 1'b0;
            for (int i = 0; i < T && !got; i++) begin
                tick("memory", DREQ | (is_wr ? DWR : 9'd0) | BUSY, 1'b0, 1'b0, 1'(i == dw), derr);
                got = (i == dw);
            end
            if (!got || derr) begin
                exp_stat = 3'd3; stop = 1'b1; return;
            end
        end
        if (k != 4'h1 && k != 4'h4 && k != 4'h7)
            tick("writeback", WB | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("pcupd", PC | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ret = exp_ret + 32'd1;
    endtask

    initial begin
        do_reset();
        // Reset state held while idle without start
        tick("reset_idle", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("reset_idle2", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // OPL with zero-wait memory, then MRMOVL with a 3-cycle data wait
        do_start();
        run_instr(4'h6, 0, 1'b0, 0, 1'b0, stopped);
        run_instr(4'h5, 0, 1'b0, 3, 1'b0, stopped);
        // RMMOVL acked on the last permitted cycle completes normally
        run_instr(4'h4, 0, 1'b0, T - 1, 1'b0, stopped);
        // Fetch acked on the last permitted cycle
        run_instr(4'h1, T - 1, 1'b0, 0, 1'b0, stopped);

        // Random legal program with random wait states
        for (int n = 0; n < 60; n++) begin
            run_instr(4'($urandom_range(1, 11)), int'($urandom_range(0, 3)), 1'b0,
                      int'($urandom_range(0, 3)), 1'b0, stopped);
        end

        // Reset while a data request is outstanding
        icode = 4'h4;
        tick("rf_fetch", IREQ | BUSY, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("rf_decode", DEC | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("rf_execute", EXE | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("rf_mem1", DREQ | DWR | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick("rf_mem2", DREQ | DWR | BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_ret = 32'd0;
        exp_stat = 3'd1;
        tick("rf_after", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("rf_idle", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // NOP then HALT; start ignored afterwards
        do_start();
        run_instr(4'h1, 0, 1'b0, 0, 1'b0, stopped);
        run_instr(4'h0, 1, 1'b0, 0, 1'b0, stopped);
        chk("halt_stop", {31'd0, stopped}, 32'd1);
        stuck("halted", 6);

        // Invalid opcode
        do_reset();
        do_start();
        run_instr(4'($urandom_range(12, 15)), 0, 1'b0, 0, 1'b0, stopped);
        stuck("ins_err", 4);

        // Instruction fetch address error
        do_reset();
        do_start();
        run_instr(4'h6, 2, 1'b1, 0, 1'b0, stopped);
        stuck("fetch_adr", 4);

        // Data memory never acknowledges
        do_reset();
        do_start();
        run_instr(4'h4, 0, 1'b0, T + 5, 1'b0, stopped);
        stuck("dmem_timeout", 4);

        // Instruction memory never acknowledges
        do_reset();
        do_start();
        run_instr(4'h1, T + 5, 1'b0, 0, 1'b0, stopped);
        stuck("imem_timeout", 3);

        // Data access address error on a POPL
        do_reset();
        do_start();
        run_instr(4'h2, 0, 1'b0, 0, 1'b0, stopped);
        run_instr(4'hB, 1, 1'b0, 2, 1'b1, stopped);
        stuck("dmem_adr", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
